// File: rtl/i2c_master.sv
// ---------------------------------------------------------------------------
// i2c_master
//   Single-byte I2C initiator. One command runs one complete bus transaction:
//   START, {addr, rw}, address ACK, one data byte (written or read), ACK/NACK
//   and STOP. SCL is generated from clk; one SCL bit lasts 4*CLK_DIV clocks,
//   split into four quarters q0..q3.
//
// Ports
//   clk      in     system clock, rising edge
//   rst_n    in     asynchronous active-low reset
//   start    in     one-cycle command strobe, accepted only while idle
//   rw       in     0 = write, 1 = read (captured on accepted start)
//   addr     in  7  target address (captured on accepted start)
//   wdata    in  8  byte to write (captured on accepted start)
//   rdata    out 8  byte read from the target, valid at done after a read
//   busy     out    high from the cycle after an accepted start through done
//   done     out    one-cycle pulse at the end of a transaction
//   ack_err  out    address or write-data ACK missing; held until next start
//   scl      out    I2C clock, push-pull, 1 when idle
//   sda      inout  I2C data, open drain (driven 0 or released)
// ---------------------------------------------------------------------------
module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    localparam int            QW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0] QLAST = QW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_AACK,
        S_WDATA,
        S_WACK,
        S_RDATA,
        S_RNACK,
        S_STOP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic          rw_q, rw_d;
    logic [6:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          samp_q, samp_d;
    logic          ack_err_q, ack_err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          scl_q, scl_d;
    logic          sda_low_q, sda_low_d;
    logic [7:0]    abyte_d;
    logic          sda_in;
    logic          qtick;

    assign sda_in = sda;
    assign sda    = sda_low_q ? 1'b0 : 1'bz;
    assign qtick  = (qcnt_q == QLAST);

    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign scl     = scl_q;

    // Next-state logic: sequencing of quarters, bits and protocol phases.
    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        samp_d    = samp_q;
        ack_err_d = ack_err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rw_d      = rw;
                    addr_d    = addr;
                    wdata_d   = wdata;
                    ack_err_d = 1'b0;
                    qcnt_d    = '0;
                    qtr_d     = 2'd0;
                    bit_d     = 3'd7;
                    state_d   = S_START;
                end
            end
            S_DONE: begin
                qcnt_d  = '0;
                qtr_d   = 2'd0;
                state_d = S_IDLE;
            end
            default: begin
                if (!qtick) begin
                    qcnt_d = qcnt_q + QW'(1);
                end else begin
                    qcnt_d = '0;
                    qtr_d  = qtr_q + 2'd1;
                    // Last clk of q2: SCL has been high for a full quarter.
                    if (qtr_q == 2'd2) begin
                        samp_d = sda_in;
                        if (state_q == S_RDATA) begin
                            rdata_d = {rdata_q[6:0], sda_in};
                        end
                    end
                    // End of the bit period: advance the protocol.
                    if (qtr_q == 2'd3) begin
                        case (state_q)
                            S_START: begin
                                state_d = S_ADDR;
                                bit_d   = 3'd7;
                            end
                            S_ADDR: begin
                                if (bit_q == 3'd0) state_d = S_AACK;
                                else               bit_d   = bit_q - 3'd1;
                            end
                            S_AACK: begin
                                bit_d = 3'd7;
                                if (samp_q) begin
                                    ack_err_d = 1'b1;
                                    state_d   = S_STOP;
                                end else begin
                                    state_d = rw_q ? S_RDATA : S_WDATA;
                                end
                            end
                            S_WDATA: begin
                                if (bit_q == 3'd0) state_d = S_WACK;
                                else               bit_d   = bit_q - 3'd1;
                            end
                            S_WACK: begin
                                if (samp_q) ack_err_d = 1'b1;
                                state_d = S_STOP;
                            end
                            S_RDATA: begin
                                if (bit_q == 3'd0) state_d = S_RNACK;
                                else               bit_d   = bit_q - 3'd1;
                            end
                            S_RNACK: state_d = S_STOP;
                            S_STOP:  state_d = S_DONE;
                            default: state_d = S_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // Pin and status values for the upcoming cycle, so the outputs come
    // straight from flops and line up with the state they belong to.
    always_comb begin
        abyte_d   = {addr_d, rw_d};
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
        case (state_d)
            S_START: begin
                scl_d     = (qtr_d != 2'd3);
                sda_low_d = qtr_d[1];           // SDA falls while SCL high
            end
            S_ADDR: begin
                scl_d     = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                sda_low_d = !abyte_d[bit_d];
            end
            S_WDATA: begin
                scl_d     = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                sda_low_d = !wdata_d[bit_d];
            end
            S_AACK, S_WACK, S_RDATA, S_RNACK: begin
                scl_d     = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                sda_low_d = 1'b0;
            end
            S_STOP: begin
                scl_d     = (qtr_d != 2'd0);
                sda_low_d = !qtr_d[1];          // SDA rises while SCL high
            end
            default: begin
                scl_d     = 1'b1;
                sda_low_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            qcnt_q    <= '0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            rw_q      <= 1'b0;
            addr_q    <= 7'd0;
            wdata_q   <= 8'd0;
            rdata_q   <= 8'd0;
            samp_q    <= 1'b0;
            ack_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            samp_q    <= samp_d;
            ack_err_q <= ack_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            scl_q     <= scl_d;
            sda_low_q <= sda_low_d;
        end
    end

endmodule
